// File: rtl/dmem_ctrl.sv
// Parametrised byte-addressed data memory with programmable latency.
// Valid/ready request and response channels, sign/zero extension, error checks.
module dmem_ctrl #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int NB    = DATA_W / 8;
   localparam int LW    = $clog2(NB);
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [2:0] LAT3 = 3'(LATENCY);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [2:0]        cnt;
   logic [2:0]        cnt_nxt;

   logic              r_we;
   logic [1:0]        r_size;
   logic              r_signed;
   logic [31:0]       r_addr;
   logic [DATA_W-1:0] r_wdata;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              accept;
   logic              fire;
   logic [ADDR_W-1:0] widx;
   logic [LW-1:0]     lane;
   logic [LW+2:0]     shamt;
   logic [6:0]        nbits;
   logic [6:0]        sa;
   logic              misal;
   logic              oor;
   logic              err;
   logic              sgn;
   logic [DATA_W-1:0] ones;
   logic [DATA_W-1:0] rword;
   logic [DATA_W-1:0] sh;
   logic [DATA_W-1:0] shl;
   logic [DATA_W-1:0] ld;
   logic [DATA_W-1:0] bm;
   logic [DATA_W-1:0] wd;
   logic [DATA_W-1:0] wnew;

   assign accept = (state == IDLE) && req_valid;
   assign fire   = (state == BUSY) && (cnt == LAT3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         IDLE: begin
            if (req_valid) begin
               state_nxt = BUSY;
               cnt_nxt   = 3'd1;
            end
         end
         BUSY: begin
            if (cnt == LAT3) begin
               state_nxt = RESP;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 3'd1;
            end
         end
         RESP: begin
            if (rsp_ready) state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      req_ready = (state == IDLE);
      rsp_valid = (state == RESP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we     <= 1'b0;
         r_size   <= '0;
         r_signed <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
      end else if (accept) begin
         r_we     <= req_we;
         r_size   <= req_size;
         r_signed <= req_signed;
         r_addr   <= req_addr;
         r_wdata  <= req_wdata;
      end
   end

   assign widx  = r_addr[LW +: ADDR_W];
   assign lane  = r_addr[LW-1:0];
   assign shamt = {lane, 3'b000};
   assign oor   = (r_addr >> (LW + ADDR_W)) != 32'd0;

   // Operand width in bits; double on a 32-bit build is clamped and flagged.
   always_comb begin
      nbits = 7'd8;
      misal = 1'b0;
      unique case (r_size)
         2'b00: begin
            nbits = 7'd8;
            misal = 1'b0;
         end
         2'b01: begin
            nbits = 7'd16;
            misal = r_addr[0];
         end
         2'b10: begin
            nbits = 7'd32;
            misal = r_addr[1:0] != 2'b00;
         end
         default: begin
            nbits = 7'(DATA_W);
            misal = (DATA_W != 64) || (r_addr[2:0] != 3'b000);
         end
      endcase
   end

   assign err   = misal || oor;
   assign sa    = 7'(DATA_W) - nbits;
   assign ones  = {DATA_W{1'b1}} >> sa;
   assign sgn   = r_signed && (r_size != 2'b11);
   assign rword = mem[widx];

   // Shift operand to the top, then back down to extend from its MSB.
   always_comb begin
      sh  = rword >> shamt;
      shl = sh << sa;
      if (sgn) ld = $signed(shl) >>> sa;
      else     ld = shl >> sa;
   end

   always_comb begin
      bm   = ones << shamt;
      wd   = r_wdata << shamt;
      wnew = (rword & ~bm) | (wd & bm);
   end

   always_ff @(posedge clk) begin
      if (fire && r_we && !err) mem[widx] <= wnew;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else if (fire) begin
         rsp_err   <= err;
         rsp_rdata <= (err || r_we) ? '0 : ld;
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: 32-bit LATENCY=1, 32-bit LATENCY=3, 64-bit builds.
// One instance is active at a time, selected by sel.
module tb_dmem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  sel = 2'd0;
   int          total = 0;
   int          bad = 0;

   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic        req_signed = 1'b0;
   logic        rsp_ready = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic [31:0] req_addr = '0;
   logic [63:0] req_wdata = '0;

   logic [2:0]  v_rdy;
   logic [2:0]  v_vld;
   logic [2:0]  v_err;
   logic [31:0] rd0;
   logic [31:0] rd1;
   logic [63:0] rd2;

   logic        req_ready;
   logic        rsp_valid;
   logic        rsp_err;
   logic [63:0] rsp_rdata;

   logic [63:0] rd;
   logic        er;
   int          lat;

   always #5 clk = ~clk;

   assign req_ready = v_rdy[sel];
   assign rsp_valid = v_vld[sel];
   assign rsp_err   = v_err[sel];
   assign rsp_rdata = (sel == 2'd0) ? {32'b0, rd0} :
                      (sel == 2'd1) ? {32'b0, rd1} : rd2;

   dmem_ctrl #(.DATA_W(32), .ADDR_W(10), .LATENCY(1)) u_l1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid && sel == 2'd0), .req_ready(v_rdy[0]),
      .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
      .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
      .rsp_valid(v_vld[0]), .rsp_ready(rsp_ready && sel == 2'd0),
      .rsp_rdata(rd0), .rsp_err(v_err[0])
   );

   dmem_ctrl #(.DATA_W(32), .ADDR_W(10), .LATENCY(3)) u_l3 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid && sel == 2'd1), .req_ready(v_rdy[1]),
      .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
      .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
      .rsp_valid(v_vld[1]), .rsp_ready(rsp_ready && sel == 2'd1),
      .rsp_rdata(rd1), .rsp_err(v_err[1])
   );

   dmem_ctrl #(.DATA_W(64), .ADDR_W(10), .LATENCY(1)) u_d64 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid && sel == 2'd2), .req_ready(v_rdy[2]),
      .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(v_vld[2]), .rsp_ready(rsp_ready && sel == 2'd2),
      .rsp_rdata(rd2), .rsp_err(v_err[2])
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 20) chk("rsp_timeout", 64'(n), 64'd0);
   endtask

   task automatic xfer(input logic we, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a,
                       input logic [63:0] w, output logic [63:0] r,
                       output logic e, output int n);
      @(negedge clk);
      req_we     = we;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = w;
      req_valid  = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      wait_rsp(n);
      r = rsp_rdata;
      e = rsp_err;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   initial begin
      #12;
      chk("rst_rdy", req_ready, 1);
      chk("rst_vld", rsp_valid, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_err", rsp_err, 0);
      @(negedge clk) rst_n = 1'b1;

      // reset in BUSY discards an uncommitted store
      xfer(1, 2'b10, 0, 32'h10, 64'h11111111, rd, er, lat);
      @(negedge clk);
      req_we = 1'b1; req_size = 2'b10; req_addr = 32'h10;
      req_wdata = 64'hCAFEF00D; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      chk("busy_rdy", req_ready, 0);
      rst_n = 1'b0;
      #1;
      chk("arst_rdy", req_ready, 1);
      chk("arst_vld", rsp_valid, 0);
      @(negedge clk) rst_n = 1'b1;
      xfer(0, 2'b10, 0, 32'h10, 0, rd, er, lat);
      chk("rst_discard", rd, 64'h11111111);

      // word store/load
      xfer(1, 2'b10, 0, 32'h20, 64'hDEADBEEF, rd, er, lat);
      chk("sw_lat", 64'(lat), 1);
      chk("sw_err", er, 0);
      chk("sw_rdata", rd, 0);
      xfer(0, 2'b10, 0, 32'h20, 0, rd, er, lat);
      chk("lw", rd, 64'hDEADBEEF);

      // byte/half extension
      xfer(1, 2'b00, 0, 32'h21, 64'h80, rd, er, lat);
      xfer(0, 2'b00, 1, 32'h21, 0, rd, er, lat);
      chk("lb", rd, 64'hFFFFFF80);
      xfer(0, 2'b00, 0, 32'h21, 0, rd, er, lat);
      chk("lbu", rd, 64'h00000080);
      xfer(0, 2'b01, 0, 32'h20, 0, rd, er, lat);
      chk("lhu", rd, 64'h000080EF);
      xfer(0, 2'b01, 1, 32'h20, 0, rd, er, lat);
      chk("lh", rd, 64'hFFFF80EF);

      // errors
      xfer(0, 2'b01, 0, 32'h23, 0, rd, er, lat);
      chk("lh_mis_err", er, 1);
      chk("lh_mis_rd", rd, 0);
      xfer(1, 2'b10, 0, 32'h22, 64'h12345678, rd, er, lat);
      chk("sw_mis_err", er, 1);
      xfer(0, 2'b10, 0, 32'h20, 0, rd, er, lat);
      chk("sw_mis_keep", rd, 64'hDEAD80EF);
      xfer(0, 2'b10, 0, 32'h1000, 0, rd, er, lat);
      chk("oor_err", er, 1);
      chk("oor_rd", rd, 0);
      xfer(0, 2'b11, 0, 32'h0, 0, rd, er, lat);
      chk("d32_err", er, 1);
      xfer(1, 2'b10, 0, 32'hFFC, 64'h5A5AC3C3, rd, er, lat);
      chk("top_sw_err", er, 0);
      xfer(0, 2'b10, 0, 32'hFFC, 0, rd, er, lat);
      chk("top_lw", rd, 64'h5A5AC3C3);

      // backpressure, LATENCY=3
      sel = 2'd1;
      xfer(1, 2'b10, 0, 32'h20, 64'hA5A5A5A5, rd, er, lat);
      chk("l3_sw_lat", 64'(lat), 3);
      @(negedge clk);
      req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
      req_addr = 32'h20; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      req_addr = 32'h31; req_size = 2'b00; req_we = 1'b1;
      wait_rsp(lat);
      chk("l3_lat", 64'(lat), 3);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_vld", rsp_valid, 1);
         chk("bp_rd", rsp_rdata, 64'hA5A5A5A5);
         chk("bp_rdy", req_ready, 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      chk("bp_rel_vld", rsp_valid, 0);
      chk("bp_rel_rdy", req_ready, 1);

      // 64-bit build
      sel = 2'd2;
      xfer(1, 2'b11, 0, 32'h8, 64'h0123456789ABCDEF, rd, er, lat);
      chk("sd_err", er, 0);
      xfer(0, 2'b10, 0, 32'hC, 0, rd, er, lat);
      chk("lwu_hi", rd, 64'h0000000001234567);
      xfer(0, 2'b10, 1, 32'h8, 0, rd, er, lat);
      chk("lw_sx64", rd, 64'hFFFFFFFF89ABCDEF);
      xfer(0, 2'b00, 0, 32'hF, 0, rd, er, lat);
      chk("lbu_l7", rd, 64'h01);
      xfer(1, 2'b01, 0, 32'hA, 64'hBEEF, rd, er, lat);
      xfer(0, 2'b11, 1, 32'h8, 0, rd, er, lat);
      chk("ld_merge", rd, 64'h01234567BEEFCDEF);
      xfer(0, 2'b11, 0, 32'h4, 0, rd, er, lat);
      chk("ld_mis_err", er, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
